noc_rr_arbiter: RTL and testbench



---
 rtl/noc_rr_arbiter_pkg.sv | 17 +
 rtl/noc_rr_pick.sv | 34 +++
 rtl/noc_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_noc_rr_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/noc_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin NoC output arbiter.
package noc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int FLITID_W_DEF = 3;
  localparam int HEAD_ID_DEF  = 1;

  // Next port index after idx, wrapping back to 0 at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Round-robin picker: first set bit of req_i at start_i, start_i+1, ... with wrap.
// When excl_start_i is set, start_i itself is skipped (used on release so the
// outgoing owner cannot immediately re-win).
module noc_rr_pick #(
  parameter int NPORTS = 5,
  parameter int IW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     start_i,
  input  logic              excl_start_i,
  output logic              found_o,
  output logic [IW-1:0]     idx_o
);

  // Linear scan from the start index; the earliest candidate in wrap order wins.
  always_comb begin
    int            c;
    logic [IW-1:0] ci;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    ci      = '0;
    for (int k = 0; k < NPORTS; k++) begin
      c = int'(start_i) + k;
      if (c >= NPORTS) c = c - NPORTS;
      ci = c[IW-1:0];
      if (!found_o && !(excl_start_i && k == 0) && req_i[ci]) begin
        found_o = 1'b1;
        idx_o   = ci;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output arbiter with per-port hold limits taken from header flits.
// A limit of 0 lets the owner hold the grant for as long as it requests.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NPORTS   = 5,
  parameter int LEN_W    = 12,
  parameter int FLITID_W = FLITID_W_DEF,
  parameter int HEAD_ID  = HEAD_ID_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req_i,
  input  logic [NPORTS*FLITID_W-1:0] flit_id_i,
  input  logic [NPORTS*LEN_W-1:0]    length_i,
  output logic [NPORTS-1:0]          grant_o,
  output logic                       grant_valid_o,
  output logic [$clog2(NPORTS)-1:0]  owner_o,
  output logic                       timeout_o
);

  localparam int IW = $clog2(NPORTS);

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [LEN_W-1:0]  limit_q [NPORTS];

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     pick_start;
  logic              pick_excl;
  logic [LEN_W-1:0]  lim_own;
  logic              expiry;
  logic              release_own;

  // One picker serves both paths: from ptr when idle, from the owner (excluded) on release.
  assign pick_start = (state_q == IDLE) ? ptr_q : owner_q;
  assign pick_excl  = (state_q == GRANT);

  noc_rr_pick #(.NPORTS(NPORTS), .IW(IW)) u_pick (
    .req_i        (req_i),
    .start_i      (pick_start),
    .excl_start_i (pick_excl),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  assign lim_own     = limit_q[owner_q];
  assign expiry      = (lim_own != '0) && (cnt_q >= lim_own - LEN_W'(1));
  assign release_own = !req_i[owner_q] || expiry;

  // Per-port limit capture on every header flit, regardless of grant state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (rst) begin
        limit_q[i] <= '0;
      end else if (flit_id_i[i*FLITID_W +: FLITID_W] == FLITID_W'(HEAD_ID)) begin
        limit_q[i] <= length_i[i*LEN_W +: LEN_W];
      end
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: stay granted while someone owns the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (release_own && !pick_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: grant vector, owner, count, pointer, timeout pulse.
  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = '0;
        end
      end
      GRANT: begin
        if (release_own) begin
          ptr_d     = IW'(wrap_inc(int'(owner_q), NPORTS));
          timeout_d = expiry;
          cnt_d     = '0;
          grant_d   = '0;
          if (pick_found) begin
            grant_d[pick_idx] = 1'b1;
            owner_d           = pick_idx;
          end else begin
            owner_d = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign owner_o       = owner_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter: a cycle-by-cycle vector table plus a few
// longer hand-written sequences (long hold, reset mid-grant).
module tb_noc_rr_arbiter;

  localparam int NP = 5;
  localparam int LW = 12;
  localparam int FW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req;
  logic [NP*FW-1:0] fid;
  logic [NP*LW-1:0] len;
  logic [NP-1:0]   grant;
  logic            gvalid;
  logic [2:0]      owner;
  logic            tout;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    int            hport;   // port carrying a header flit this cycle, -1 for none
    int            hlen;
    logic [NP-1:0] g;
    logic          to;
  } vec_t;

  vec_t vecs[$];

  noc_rr_arbiter #(.NPORTS(NP), .LEN_W(LW), .FLITID_W(FW), .HEAD_ID(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .flit_id_i     (fid),
    .length_i      (len),
    .grant_o       (grant),
    .grant_valid_o (gvalid),
    .owner_o       (owner),
    .timeout_o     (tout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [NP-1:0] rq, input int hp,
                              input int hl, input logic [NP-1:0] g, input logic to);
    vec_t v;
    v.rst = r; v.req = rq; v.hport = hp; v.hlen = hl; v.g = g; v.to = to;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [NP-1:0] rq, input int hp, input int hl);
    @(negedge clk);
    rst = r;
    req = rq;
    fid = '0;
    len = '0;
    if (hp >= 0) begin
      fid[hp*FW +: FW] = 3'd1;
      len[hp*LW +: LW] = LW'(hl);
    end
  endtask

  task automatic check(input string name, input logic [NP-1:0] eg, input logic eto);
    logic [2:0] eo;
    eo = '0;
    for (int i = 0; i < NP; i++) if (eg[i]) eo = 3'(i);
    @(posedge clk);
    #1;
    n_vec++;
    if (grant !== eg || tout !== eto || gvalid !== (|eg) || owner !== eo) begin
      n_bad++;
      $display("FAIL %s: got grant=%b timeout=%b valid=%b owner=%0d, want grant=%b timeout=%b valid=%b owner=%0d",
               name, grant, tout, gvalid, owner, eg, eto, |eg, eo);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; fid = '0; len = '0;

    // reset with all requesting, then round robin 0..4,0 with 3-cycle holds
    vecs.push_back(mk(1, 5'b11111, -1, 0, 5'b00000, 0));
    vecs.push_back(mk(1, 5'b11111, -1, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 5'b11110, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b11101, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b11011, -1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 5'b10111, -1, 0, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b11111, -1, 0, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b01111, -1, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 5'b00000, -1, 0, 5'b00000, 0));   // ptr now 1
    // port 2 limit 4: held exactly 4 cycles, timeout with handover to port 3
    vecs.push_back(mk(0, 5'b00000,  2, 4, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b01000, 1));
    vecs.push_back(mk(0, 5'b01100, -1, 0, 5'b01000, 0));
    // timed-out port 2 wins back once port 3 releases
    vecs.push_back(mk(0, 5'b00100, -1, 0, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b00000, -1, 0, 5'b00000, 0));   // ptr now 3
    // port 1 limit 2, req drops in the expiry cycle: timeout still pulses
    vecs.push_back(mk(0, 5'b00000,  1, 2, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00000, -1, 0, 5'b00000, 1));
    // port 1 drops with no other requester -> idle, then regrant
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00000, -1, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00000, -1, 0, 5'b00000, 0));
    // limit lowered mid-grant from 2 to 1 with count already 1 -> release next cycle
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00010,  1, 1, 5'b00010, 0));
    vecs.push_back(mk(0, 5'b00010, -1, 0, 5'b00000, 1));

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].rst, vecs[v].req, vecs[v].hport, vecs[v].hlen);
      check($sformatf("vec%0d", v), vecs[v].g, vecs[v].to);
    end

    // port 0 alone with limit 0 holds for 100 cycles, no timeout
    for (int k = 0; k < 100; k++) begin
      drive(0, 5'b00001, -1, 0);
      check($sformatf("hold0_%0d", k), 5'b00001, 1'b0);
    end

    // hand over to port 4 (ptr becomes 1), hold until count reaches 7
    drive(0, 5'b10000, -1, 0);
    check("to_port4", 5'b10000, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(0, 5'b10000, -1, 0);
      check($sformatf("hold4_%0d", k), 5'b10000, 1'b0);
    end
    drive(1, 5'b10001, -1, 0);
    check("rst_midgrant", 5'b00000, 1'b0);
    drive(0, 5'b10001, -1, 0);
    check("ptr_cleared", 5'b00001, 1'b0);

    // reset also clears limits: port 1 (limit 1 before reset) now holds past one cycle
    drive(0, 5'b00010, -1, 0);
    check("to_port1", 5'b00010, 1'b0);
    drive(0, 5'b00010, -1, 0);
    check("limit_cleared", 5'b00010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
